// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 types, bus FSM states and reset constants
package sm83_pkg;

  typedef enum logic {
    ADDR_PC   = 1'b0,
    ADDR_GP16 = 1'b1
  } addr_sel_t;

  typedef enum logic {
    BUS_RUN  = 1'b0,
    BUS_WAIT = 1'b1
  } bus_state_t;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

  // One resolved memory access: what goes on the bus and what happens on completion
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    logic        to_z;
    logic        to_w;
    logic        to_ir;
    logic        to_r8;
    logic        inc_pc;
  } bus_req_t;

endpackage

// File: rtl/bus_unit_if.sv
// rtl/bus_unit_if.sv - external memory bus of bus_unit (mem_ready only with BUS_WAIT_EN)
interface bus_unit_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
`ifdef BUS_WAIT_EN
  logic        mem_ready;

  modport master (output mem_addr, mem_wdata, mem_rd, mem_wr, input mem_rdata, mem_ready);
  modport slave  (input mem_addr, mem_wdata, mem_rd, mem_wr, output mem_rdata, mem_ready);
`else
  modport master (output mem_addr, mem_wdata, mem_rd, mem_wr, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_rd, mem_wr, output mem_rdata);
`endif
endinterface

// File: rtl/bus_unit_pc_counter.sv
// rtl/bus_unit_pc_counter.sv - 16-bit program counter with enable-gated wrapping increment
module pc_counter
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  // Increment wraps naturally from 16'hFFFF to 16'h0000
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VAL;
    else if (en) q <= q + 16'd1;
  end

endmodule

// File: rtl/bus_unit.sv
// rtl/bus_unit.sv - SM83 memory-side stage: PC/IR/Z/W and one bus access per M-cycle (wait states with BUS_WAIT_EN)
module bus_unit
  import sm83_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  addr_sel_t   addr_sel,
  input  logic        inc_pc,
  input  logic        mem_to_z,
  input  logic        mem_to_w,
  input  logic        mem_to_ir,
  input  logic        mem_to_r8,
  input  logic        r8_to_mem,
  input  logic        z_to_mem,
  input  logic        halt,
  input  logic [15:0] gp16_addr,
  input  logic [7:0]  r8_data,
  output logic [15:0] pc,
  output logic [7:0]  ir,
  output logic [7:0]  z,
  output logic [7:0]  w,
  output logic [7:0]  r8_wdata,
  output logic        r8_we,
  output logic        stall,
  bus_unit_if.master  bus
);

  bus_state_t state;
  bus_req_t   live;
  bus_req_t   held;
  bus_req_t   cur;
  logic       ready;
  logic       has_access;
  logic       done;

`ifdef BUS_WAIT_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Decode this cycle's strobes: writes beat reads, r8 beats Z, halt kills everything
  always_comb begin
    live = '0;
    if (!halt) begin
      live.wr     = r8_to_mem | z_to_mem;
      live.rd     = !live.wr && (mem_to_z | mem_to_w | mem_to_ir | mem_to_r8);
      live.addr   = (addr_sel == ADDR_PC) ? pc : gp16_addr;
      live.wdata  = r8_to_mem ? r8_data : z;
      live.to_z   = live.rd & mem_to_z;
      live.to_w   = live.rd & mem_to_w;
      live.to_ir  = live.rd & mem_to_ir;
      live.to_r8  = live.rd & mem_to_r8;
      live.inc_pc = inc_pc;
    end
  end

  // A stretched access replays its latched request; reset silences the bus
  always_comb begin
    cur = '0;
    if (!rst) cur = (state == BUS_WAIT) ? held : live;
  end

  assign has_access    = cur.rd | cur.wr;
  assign done          = !has_access || ready;
  assign stall         = !done;

  assign bus.mem_addr  = has_access ? cur.addr : 16'h0000;
  assign bus.mem_rd    = cur.rd;
  assign bus.mem_wr    = cur.wr;
  assign bus.mem_wdata = cur.wr ? cur.wdata : 8'h00;
  assign r8_we         = done & cur.to_r8;
  assign r8_wdata      = bus.mem_rdata;

  pc_counter #(.RESET_VAL(PC_RESET)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (done & cur.inc_pc),
    .q   (pc)
  );

  // Bus FSM: capture read data on completion, otherwise park the request in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BUS_RUN;
      held  <= '0;
      ir    <= 8'h00;
      z     <= 8'h00;
      w     <= 8'h00;
    end else if (done) begin
      state <= BUS_RUN;
      if (cur.to_z)  z  <= bus.mem_rdata;
      if (cur.to_w)  w  <= bus.mem_rdata;
      if (cur.to_ir) ir <= bus.mem_rdata;
    end else if (state == BUS_RUN) begin
      held  <= cur;
      state <= BUS_WAIT;
    end
  end

endmodule

// File: tb/tb_bus_unit.sv
// tb/tb_bus_unit.sv - self-checking bench for bus_unit (wait-state steps only with BUS_WAIT_EN)
module tb_bus_unit;
  import sm83_pkg::*;

  localparam logic [15:0] PCR = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  addr_sel_t   addr_sel;
  logic        inc_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8, r8_to_mem, z_to_mem, halt;
  logic [15:0] gp16_addr;
  logic [7:0]  r8_data;
  logic [15:0] pc;
  logic [7:0]  ir, z, w, r8_wdata;
  logic        r8_we, stall;
  logic [7:0]  rdata;
  logic        rdy;

  int total = 0;
  int bad   = 0;

  bus_unit_if bus ();
  assign bus.mem_rdata = rdata;
`ifdef BUS_WAIT_EN
  assign bus.mem_ready = rdy;
`endif

  bus_unit #(.PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst), .addr_sel(addr_sel), .inc_pc(inc_pc),
    .mem_to_z(mem_to_z), .mem_to_w(mem_to_w), .mem_to_ir(mem_to_ir), .mem_to_r8(mem_to_r8),
    .r8_to_mem(r8_to_mem), .z_to_mem(z_to_mem), .halt(halt),
    .gp16_addr(gp16_addr), .r8_data(r8_data),
    .pc(pc), .ir(ir), .z(z), .w(w), .r8_wdata(r8_wdata), .r8_we(r8_we), .stall(stall),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [15:0] m_pc;
  logic [7:0]  m_ir, m_z, m_w;
  bit          m_wait;
  logic [15:0] q_addr;
  logic [7:0]  q_wdata;
  bit          q_rd, q_wr, q_cz, q_cw, q_ci, q_cr, q_inc;
  // access seen this cycle
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  bit          a_rd, a_wr, a_cz, a_cw, a_ci, a_cr, a_inc, a_done;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = PCR; m_ir = 8'h00; m_z = 8'h00; m_w = 8'h00; m_wait = 0;
  endtask

  function automatic bit eff_ready();
`ifdef BUS_WAIT_EN
    return rdy;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_eval();
    if (m_wait) begin
      a_addr = q_addr; a_wdata = q_wdata; a_rd = q_rd; a_wr = q_wr;
      a_cz = q_cz; a_cw = q_cw; a_ci = q_ci; a_cr = q_cr; a_inc = q_inc;
    end else if (halt) begin
      a_addr = 16'h0; a_wdata = 8'h0; a_rd = 0; a_wr = 0;
      a_cz = 0; a_cw = 0; a_ci = 0; a_cr = 0; a_inc = 0;
    end else begin
      a_wr    = r8_to_mem || z_to_mem;
      a_rd    = !a_wr && (mem_to_z || mem_to_w || mem_to_ir || mem_to_r8);
      a_addr  = (addr_sel == ADDR_PC) ? m_pc : gp16_addr;
      a_wdata = r8_to_mem ? r8_data : m_z;
      a_cz = a_rd && mem_to_z; a_cw = a_rd && mem_to_w;
      a_ci = a_rd && mem_to_ir; a_cr = a_rd && mem_to_r8;
      a_inc = inc_pc;
    end
    a_done = !(a_rd || a_wr) || eff_ready();
  endtask

  task automatic model_commit();
    if (a_done) begin
      if (a_cz) m_z = rdata;
      if (a_cw) m_w = rdata;
      if (a_ci) m_ir = rdata;
      if (a_inc) m_pc = m_pc + 16'd1;
      m_wait = 0;
    end else if (!m_wait) begin
      q_addr = a_addr; q_wdata = a_wdata; q_rd = a_rd; q_wr = a_wr;
      q_cz = a_cz; q_cw = a_cw; q_ci = a_ci; q_cr = a_cr; q_inc = a_inc;
      m_wait = 1;
    end
  endtask

  // One clock: check bus outputs mid-cycle, then registers just after the edge
  task automatic run_cycle();
    #2;
    model_eval();
    chk("mem_addr", bus.mem_addr, (a_rd || a_wr) ? a_addr : 16'h0000);
    chk("mem_rd", {15'd0, bus.mem_rd}, {15'd0, a_rd});
    chk("mem_wr", {15'd0, bus.mem_wr}, {15'd0, a_wr});
    chk("mem_wdata", {8'd0, bus.mem_wdata}, {8'd0, a_wr ? a_wdata : 8'h00});
    chk("stall", {15'd0, stall}, {15'd0, !a_done});
    chk("r8_we", {15'd0, r8_we}, {15'd0, a_done && a_cr});
    if (a_done && a_cr) chk("r8_wdata", {8'd0, r8_wdata}, {8'd0, rdata});
    @(posedge clk);
    #1;
    model_commit();
    chk("pc", pc, m_pc);
    chk("ir", {8'd0, ir}, {8'd0, m_ir});
    chk("z", {8'd0, z}, {8'd0, m_z});
    chk("w", {8'd0, w}, {8'd0, m_w});
  endtask

  task automatic clear_strobes();
    inc_pc = 0; mem_to_z = 0; mem_to_w = 0; mem_to_ir = 0; mem_to_r8 = 0;
    r8_to_mem = 0; z_to_mem = 0; halt = 0;
  endtask

  initial begin
    // reset with strobes active: bus must stay quiet
    rst = 1'b1; clear_strobes(); addr_sel = ADDR_PC; gp16_addr = 16'h0; r8_data = 8'h0;
    rdata = 8'h0; rdy = 1'b1; mem_to_ir = 1; inc_pc = 1;
    #12;
    chk("rst_pc", pc, PCR);
    chk("rst_ir", {8'd0, ir}, 16'h0000);
    chk("rst_z", {8'd0, z}, 16'h0000);
    chk("rst_w", {8'd0, w}, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'h0000);
    chk("rst_mem_rd", {15'd0, bus.mem_rd}, 16'h0000);
    chk("rst_mem_wr", {15'd0, bus.mem_wr}, 16'h0000);
    chk("rst_r8_we", {15'd0, r8_we}, 16'h0000);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // opcode fetch from PC
    clear_strobes(); mem_to_ir = 1; inc_pc = 1; addr_sel = ADDR_PC; rdata = 8'h3E;
    #1;
    chk("fetch_addr", bus.mem_addr, PCR);
    chk("fetch_rd", {15'd0, bus.mem_rd}, 16'h0001);
    run_cycle();
    chk("fetch_ir", {8'd0, ir}, 16'h003E);
    chk("fetch_pc", pc, 16'hFFFF);

    // read with increment across the wrap point
    clear_strobes(); mem_to_w = 1; inc_pc = 1; rdata = 8'hA5;
    run_cycle();
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_w", {8'd0, w}, 16'h00A5);

    // write via GP16; read and Z-write strobes must lose
    clear_strobes(); addr_sel = ADDR_GP16; gp16_addr = 16'hC000; r8_data = 8'h5A;
    r8_to_mem = 1; z_to_mem = 1; mem_to_z = 1; rdata = 8'hFF;
    #1;
    chk("wr_addr", bus.mem_addr, 16'hC000);
    chk("wr_mem_wr", {15'd0, bus.mem_wr}, 16'h0001);
    chk("wr_mem_rd", {15'd0, bus.mem_rd}, 16'h0000);
    chk("wr_wdata", {8'd0, bus.mem_wdata}, 16'h005A);
    run_cycle();
    chk("wr_pc", pc, 16'h0000);
    chk("wr_z", {8'd0, z}, 16'h0000);

    // halt freezes everything
    clear_strobes(); halt = 1; mem_to_ir = 1; inc_pc = 1; addr_sel = ADDR_PC; rdata = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("halt_rd", {15'd0, bus.mem_rd}, 16'h0000);
      run_cycle();
      chk("halt_ir", {8'd0, ir}, 16'h003E);
      chk("halt_pc", pc, 16'h0000);
    end

`ifdef BUS_WAIT_EN
    // two wait states; live inputs change while the latched access is replayed
    clear_strobes(); mem_to_z = 1; addr_sel = ADDR_GP16; gp16_addr = 16'h1234; rdy = 0; rdata = 8'h00;
    #1;
    chk("w1_stall", {15'd0, stall}, 16'h0001);
    run_cycle();
    clear_strobes(); gp16_addr = 16'h5678; r8_to_mem = 1;
    #1;
    chk("w2_stall", {15'd0, stall}, 16'h0001);
    chk("w2_addr", bus.mem_addr, 16'h1234);
    run_cycle();
    rdy = 1; rdata = 8'h77;
    #1;
    chk("w3_stall", {15'd0, stall}, 16'h0000);
    chk("w3_addr", bus.mem_addr, 16'h1234);
    run_cycle();
    chk("w3_z", {8'd0, z}, 16'h0077);

    // reset while waiting abandons the access
    clear_strobes(); mem_to_ir = 1; inc_pc = 1; addr_sel = ADDR_PC; rdy = 0;
    run_cycle();
    rst = 1'b1;
    #2;
    chk("wrst_stall", {15'd0, stall}, 16'h0000);
    chk("wrst_rd", {15'd0, bus.mem_rd}, 16'h0000);
    chk("wrst_pc", pc, PCR);
    chk("wrst_z", {8'd0, z}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      addr_sel  = ($urandom_range(0, 1) == 0) ? ADDR_PC : ADDR_GP16;
      inc_pc    = $urandom_range(0, 1) == 1;
      mem_to_z  = $urandom_range(0, 3) == 0;
      mem_to_w  = $urandom_range(0, 3) == 0;
      mem_to_ir = $urandom_range(0, 3) == 0;
      mem_to_r8 = $urandom_range(0, 3) == 0;
      r8_to_mem = $urandom_range(0, 5) == 0;
      z_to_mem  = $urandom_range(0, 5) == 0;
      halt      = $urandom_range(0, 7) == 0;
      gp16_addr = 16'($urandom);
      r8_data   = 8'($urandom);
      rdata     = 8'($urandom);
      rdy       = $urandom_range(0, 3) != 0;
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_unit.md
# bus_unit

Memory-side datapath stage directly downstream of the SM83 control sequencer. Holds PC, IR and the Z/W temporaries and turns the sequencer's per-cycle strobes (address select, PC increment, memory-to-register captures, register-to-memory writes) into one external 8-bit memory access per M-cycle. Optionally stretches an access with memory wait states, back-pressuring the sequencer through `stall`.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_sel  in  addr_sel_t  PC or GP16 address source.
- inc_pc  in  1  increment PC when the current cycle completes.
- mem_to_z / mem_to_w / mem_to_ir / mem_to_r8  in  1 each  read-capture strobes.
- r8_to_mem / z_to_mem  in  1 each  write strobes (data from r8_data / Z).
- halt  in  1  CPU halted; no new accesses.
- gp16_addr  in  16  register-pair address from register file.
- r8_data  in  8  register-file write data.
- pc  out  16  program counter.
- ir  out  8  instruction register (to decoder).
- z, w  out  8 each  temporaries.
- r8_wdata  out  8  read data for register file; r8_we  out  1  its write enable.
- stall  out  1  access not complete; sequencer must hold its step index.
- mem_addr  out  16; mem_wdata  out  8; mem_rd, mem_wr  out  1 each.
- mem_rdata  in  8  read data, valid when mem_ready high.
- mem_ready  in  1  access completes this cycle (present only with BUS_WAIT_EN).

## Operation
- Access type per cycle: write if r8_to_mem or z_to_mem; else read if any mem_to_*; else none. Write plus read strobes together: write wins, reads suppressed. r8_to_mem and z_to_mem together: r8_data wins.
- Address: addr_sel==PC → pc; GP16 → gp16_addr.
- States: BUS_RUN, BUS_WAIT.
  - RUN, access requested, mem_ready=1: completes this cycle; stay RUN.
  - RUN, access requested, mem_ready=0: latch address, type, write data, capture strobes and inc_pc; go WAIT; stall=1.
  - WAIT: drive latched values, ignore live strobes; stall=1 while mem_ready=0; mem_ready=1 → complete, stall=0, go RUN.
  - RUN, no access: completes immediately (inc_pc alone still applies).
- On completion edge: each asserted mem_to_z/w/ir loads mem_rdata into that register; mem_to_r8 asserts r8_we=1 for that cycle with r8_wdata=mem_rdata (combinational, regfile samples same edge); inc_pc → pc+1, wrapping 16'hFFFF→16'h0000.
- halt=1 in RUN: mem_rd=mem_wr=0, no captures, pc/ir/z/w frozen. halt rising during WAIT: current access finishes first, then halt applies.
- mem_wdata driven only when mem_wr=1; else 8'h00.

## Timing
- Reset values: pc=PC_RESET, ir=8'h00 (NOP), z=w=8'h00, state=RUN, stall=0, mem_rd=mem_wr=0, r8_we=0, mem_addr=16'h0000.
- Zero-wait access: strobes, mem_addr, mem_rd/mem_wr combinational in the same cycle; result registered at the closing edge; 1 cycle total.
- Each mem_ready=0 cycle adds exactly one stall cycle; stall is combinational (depends on mem_ready).
- Reset asserted during WAIT: access abandoned, no capture, no PC increment; strobes low within reset.

## Configuration
- BUS_WAIT_EN defined: mem_ready port and BUS_WAIT state exist as above.
- BUS_WAIT_EN undefined: no mem_ready port; every access completes in its cycle; stall tied 0; FSM reduces to RUN only.

## Structure
- sm83_pkg: existing addr_sel_t; add bus_state_t {BUS_RUN, BUS_WAIT} and constant PC_RESET_DEFAULT=16'h0000.
- One sub-module: pc_counter (16-bit register, async reset to parameter, enable-gated +1 with wrap).

## Test plan
- Reset then mem_to_ir+inc_pc, addr_sel=PC, mem_rdata=8'h3E → mem_addr=0000, mem_rd=1, ir=3E, pc=0001 after one edge.
- pc=FFFF, inc_pc with read → pc=0000 after completion.
- GP16=C000, r8_to_mem, r8_data=5A → mem_addr=C000, mem_wr=1, mem_wdata=5A, pc unchanged.
- BUS_WAIT_EN: mem_to_z, mem_ready low 2 cycles then high with 8'h77 → stall=1 for 2 cycles, z=77 on third edge, addr stable throughout.
- halt=1 with mem_to_ir asserted → mem_rd=0, ir and pc unchanged for 5 cycles.
- BUS_WAIT_EN: rst pulsed mid-WAIT → state RUN, stall=0, pc=PC_RESET, z unchanged from reset value 00.
